fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the single IF/ID register with a DEPTH-entry prefetch queue of {pc, instr} pairs. It drives the instruction-memory port, which has a one-cycle synchronous read, and absorbs ID-stage stalls without losing fetched words. A redirect from ID-stage branch resolution kills every younger entry, including the word in flight.

---
 rtl/rv_pipe_pkg.sv | 9 +
 rtl/fq_ring.sv | 39 +++
 rtl/fetch_queue.sv | 67 ++++++
 tb/tb_fetch_queue.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared constants and the queue entry type for the pipelined core front end
package rv_pipe_pkg;
    localparam int RV_XLEN = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [31:0]        instr;
    } fq_entry_t;
endpackage

// File: rtl/fq_ring.sv
// fq_ring: power-of-two ring buffer with push/pop/clear and a combinational head read
module fq_ring
    import rv_pipe_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fq_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    T mem [DEPTH];
    logic [AW-1:0] head, tail;
    always_ff @(posedge clk)
        if (push && !clear && !rst)
            mem[tail] <= push_data;
    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head_data = mem[head];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-based prefetch queue between a 1-cycle instruction memory and ID
module fetch_queue
    import rv_pipe_pkg::*;
#(
    parameter int               XLEN     = RV_XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       instr_read,
    output logic [XLEN-1:0]            instr_addr,
    input  logic [31:0]                instr_out,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [31:0]                id_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;
    logic [XLEN-1:0] fetch_pc, inflight_pc, target_pc;
    logic            inflight, pop, push;
    logic [CW:0]     need;
    entry_t          head;
    assign target_pc  = redirect_pc & ~XLEN'(3);
    assign id_valid   = ~rst & ~redirect & (count != '0);
    assign id_pc      = id_valid ? head.pc : '0;
    assign id_instr   = id_valid ? head.instr : RV_NOP;
    assign pop        = id_valid & id_ready;
    assign push       = inflight & ~redirect & ~rst;
    // The inflight word already owns a slot, so it counts against space before it lands.
    assign need       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign instr_read = ~rst & ~redirect & (need < (CW+1)'(DEPTH));
    assign instr_addr = fetch_pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= instr_read;
            if (instr_read) begin
                fetch_pc    <= fetch_pc + XLEN'(4);
                inflight_pc <= fetch_pc;
            end
        end
    end
    fq_ring #(.DEPTH(DEPTH), .T(entry_t)) u_ring (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (push),
        .push_data ('{pc: inflight_pc, instr: instr_out}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic checked against a queue-level model
module tb_fetch_queue;
    import rv_pipe_pkg::*;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic [31:0] instr_out = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [$clog2(DEPTH+1)-1:0] count;
    int checks = 0;
    int failures = 0;
    logic [31:0] mq [$];
    logic        minf = 1'b0;
    logic [31:0] mipc = '0;
    logic [31:0] mpc = '0;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_read  (instr_read),
        .instr_addr  (instr_addr),
        .instr_out   (instr_out),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory answers one cycle after the request; garbage otherwise to expose false pushes.
    always @(posedge clk)
        instr_out <= instr_read ? mem_word(instr_addr) : $urandom;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
        logic ev, ei, pop;
        int n;
        rst = r;
        redirect = rd;
        redirect_pc = rp;
        id_ready = rdy;
        #1;
        n = mq.size();
        ev = !r && !rd && n > 0;
        pop = ev && rdy;
        ei = !r && !rd && (n + int'(minf) - int'(pop) < DEPTH);
        check("id_valid", id_valid, ev);
        check("instr_read", instr_read, ei);
        if (!r) begin
            check("id_pc", id_pc, ev ? mq[0] : 32'h0);
            check("id_instr", id_instr, ev ? mem_word(mq[0]) : RV_NOP);
            check("count", count, n);
            check("instr_addr", instr_addr, mpc);
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            minf = 1'b0;
            mpc = RESET_PC;
        end else if (rd) begin
            mq.delete();
            minf = 1'b0;
            mpc = rp & ~32'd3;
        end else begin
            if (pop)
                void'(mq.pop_front());
            if (minf)
                mq.push_back(mipc);
            minf = ei;
            if (ei) begin
                mipc = mpc;
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        repeat (2) cyc(1, 0, 0, 1);
        repeat (8) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0);
        check("stall_full", count, DEPTH);
        check("stall_noread", instr_read, 0);
        repeat (10) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        check("pre_redir_count", count, 3);
        cyc(0, 1, 32'h103, 1);
        check("redir_addr", instr_addr, 32'h100);
        repeat (4) cyc(0, 0, 0, 1);
        repeat (8) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h40, 1);
        check("redir_full_empty", count, 0);
        repeat (5) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        rst = 1'b0;
        redirect = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_nop", id_instr, RV_NOP);
        check("rst_addr", instr_addr, RESET_PC);
        repeat (4) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'hFFFF_FFFC, 1);
        repeat (6) cyc(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom,
                $urandom_range(0, 9) < 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
